// File: rtl/conv_encode_tx_pkg.sv
// Shared constants for the K=9, rate-1/2 transmit convolutional encoder.
// Holds the generator polynomials, code width and framing FSM encodings.
package conv_encode_tx_pkg;
    localparam int K_CONV   = 9;
    localparam int MEM_CONV = K_CONV - 1;
    localparam int WD_CODE  = 2;

    // Bit K-1 of each generator taps the newest input bit.
    localparam logic [K_CONV-1:0] G0_CONV = 9'o561;
    localparam logic [K_CONV-1:0] G1_CONV = 9'o753;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } fsm_state_t;
endpackage

// File: rtl/conv_encode_core.sv
// Encoder memory plus both generator parity trees.
// code_out is combinational from the current input bit and the held state.
module conv_encode_core
    import conv_encode_tx_pkg::*;
(
    input  logic                CLOCK,
    input  logic                Reset,
    input  logic                shift_en,
    input  logic                bit_in,
    input  logic                clear,
    output logic [WD_CODE-1:0]  code_out,
    output logic [MEM_CONV-1:0] state_out
);
    logic [MEM_CONV-1:0] state_reg;
    logic [K_CONV-1:0]   r_vec;
    logic [K_CONV-1:0]   tap0;
    logic [K_CONV-1:0]   tap1;

    // r_vec[K-1] is the current bit, state_reg[MEM-1] the previous one.
    assign r_vec = {bit_in, state_reg};

    genvar gi;
    generate
        for (gi = 0; gi < K_CONV; gi++) begin : g_tap
            assign tap0[gi] = r_vec[gi] & G0_CONV[gi];
            assign tap1[gi] = r_vec[gi] & G1_CONV[gi];
        end
    endgenerate

    assign code_out  = {^tap0, ^tap1};
    assign state_out = state_reg;

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state_reg <= '0;
        end else if (shift_en) begin
            state_reg <= {bit_in, state_reg[MEM_CONV-1:1]};
        end else if (clear) begin
            state_reg <= '0;
        end
    end
endmodule

// File: rtl/conv_encode_tx.sv
// Framed transmit encoder: byte buffer, MSB-first serialiser, symbol-rate divider,
// tail insertion so the decoder trellis terminates in state 0.
module conv_encode_tx
    import conv_encode_tx_pkg::*;
#(
    parameter int SYM_DIV = 4
)
(
    input  logic               CLOCK,
    input  logic               Reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [WD_CODE-1:0] Code,
    output logic               sym_valid,
    output logic               Active,
    output logic               frame_done,
    output logic               err_underrun,
    input  logic               clr_err
);
    localparam int DIV_W = $clog2(SYM_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);

    fsm_state_t          state_reg, state_next;
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [2:0]          bit_cnt_reg, bit_cnt_next;
    logic [2:0]          tail_cnt_reg, tail_cnt_next;
    logic [7:0]          cur_byte_reg, cur_byte_next;
    logic                cur_last_reg, cur_last_next;
    logic [7:0]          buf_data_reg;
    logic                buf_last_reg;
    logic                buf_full_reg, buf_full_next;
    logic [WD_CODE-1:0]  code_reg;
    logic                sym_valid_reg;
    logic                active_reg, active_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    logic                slot;
    logic                take;
    logic                load;
    logic                shift_en;
    logic                bit_in;
    logic                core_clear;
    logic [WD_CODE-1:0]  core_code;
    logic [MEM_CONV-1:0] core_state;

    conv_encode_core u_core (
        .CLOCK     (CLOCK),
        .Reset     (Reset),
        .shift_en  (shift_en),
        .bit_in    (bit_in),
        .clear     (core_clear),
        .code_out  (core_code),
        .state_out (core_state)
    );

    assign slot = (div_reg == DIV_LAST);
    assign load = in_valid && !buf_full_reg;

    // Tail bits already return the state to 0; this only guards idle time.
    assign core_clear = (state_reg == ST_IDLE) && !buf_full_reg && (|core_state);

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        bit_cnt_next  = bit_cnt_reg;
        tail_cnt_next = tail_cnt_reg;
        cur_byte_next = cur_byte_reg;
        cur_last_next = cur_last_reg;
        buf_full_next = buf_full_reg;
        active_next   = active_reg;
        done_next     = 1'b0;
        err_next      = clr_err ? 1'b0 : err_reg;
        shift_en      = 1'b0;
        bit_in        = 1'b0;
        take          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                div_next = '0;
                take     = buf_full_reg;
            end
            ST_DATA: begin
                div_next = slot ? '0 : div_reg + 1'b1;
                if (slot) begin
                    if (bit_cnt_reg != 3'd0) begin
                        shift_en      = 1'b1;
                        bit_in        = cur_byte_reg[7];
                        cur_byte_next = {cur_byte_reg[6:0], 1'b0};
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                    end else if (cur_last_reg) begin
                        shift_en      = 1'b1;
                        tail_cnt_next = 3'd1;
                        state_next    = ST_TAIL;
                    end else if (buf_full_reg) begin
                        take = 1'b1;
                    end else begin
                        // Underrun: hold the trellis, keep the frame open.
                        err_next = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                div_next = slot ? '0 : div_reg + 1'b1;
                if (slot) begin
                    if (tail_cnt_reg != 3'd0) begin
                        shift_en      = 1'b1;
                        tail_cnt_next = tail_cnt_reg + 3'd1;
                    end else begin
                        done_next   = 1'b1;
                        active_next = 1'b0;
                        state_next  = ST_IDLE;
                        div_next    = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (take) begin
            shift_en      = 1'b1;
            bit_in        = buf_data_reg[7];
            cur_byte_next = {buf_data_reg[6:0], 1'b0};
            cur_last_next = buf_last_reg;
            bit_cnt_next  = 3'd1;
            buf_full_next = 1'b0;
            active_next   = 1'b1;
            state_next    = ST_DATA;
            div_next      = '0;
        end

        if (load) begin
            buf_full_next = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state_reg     <= ST_IDLE;
            div_reg       <= '0;
            bit_cnt_reg   <= '0;
            tail_cnt_reg  <= '0;
            cur_byte_reg  <= '0;
            cur_last_reg  <= 1'b0;
            buf_data_reg  <= '0;
            buf_last_reg  <= 1'b0;
            buf_full_reg  <= 1'b0;
            code_reg      <= '0;
            sym_valid_reg <= 1'b0;
            active_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            bit_cnt_reg   <= bit_cnt_next;
            tail_cnt_reg  <= tail_cnt_next;
            cur_byte_reg  <= cur_byte_next;
            cur_last_reg  <= cur_last_next;
            buf_full_reg  <= buf_full_next;
            sym_valid_reg <= shift_en;
            active_reg    <= active_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            if (load) begin
                buf_data_reg <= in_data;
                buf_last_reg <= in_last;
            end
            if (shift_en) begin
                code_reg <= core_code;
            end
        end
    end

    assign in_ready     = !buf_full_reg;
    assign Code         = code_reg;
    assign sym_valid    = sym_valid_reg;
    assign Active       = active_reg;
    assign frame_done   = done_reg;
    assign err_underrun = err_reg;
endmodule
